lsu: RTL and testbench

//  Load/store unit downstream of the single-cycle core's EX stage. It takes the

---
 rtl/lsu_if.sv | 30 +++
 rtl/lsu.sv | 180 ++++++++++++++++++
 tb/tb_lsu.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit and memory.
//   mem_req   : request, held high until mem_ack (or timeout)
//   mem_we    : 1 = write
//   mem_addr  : word-aligned address
//   mem_wdata : lane-replicated store data
//   mem_wstrb : byte enables, 0 on reads
//   mem_ack   : completion; mem_rdata is valid in the same cycle
//   mem_rdata : read word
// Handshake: a transfer completes on the first rising clk edge where
// mem_req and mem_ack are both high. The master keeps every request field
// stable while mem_req is high. mem_ack is ignored while mem_req is low.
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit placed after the EX stage of a single-cycle core.
// Runs one access per load/store on the lsu_if bus, stalls the core while
// the access is in flight, and returns the extended load result.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   load/store : decoded instruction type (held while stall=1)
//   funct3     : 0 B, 1 H, 2 W, 4 BU, 5 HU
//   addr/wdata : effective address and store data
//   stall      : hold PC/instruction
//   done       : one-cycle pulse, rdata/err valid
//   rdata/err  : extended load result, error flag
//   dbg_state  : current FSM state (0 IDLE, 1 REQ, 2 DONE)
//   mem        : lsu_if master modport
//
// Parameter TIMEOUT_CYC: REQ cycles allowed without mem_ack (0 = wait forever).
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword/word
// accesses end with err=1 and no bus access; when undefined, the low address
// bits below natural alignment are ignored.
module lsu #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  dbg_state,
  lsu_if.master       mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] cnt;

  logic        bad_op;
  logic        misalign;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Decode of the incoming access. A store wins when load and store are both
  // high, so store legality (B/H/W only) is checked first.
  always_comb begin
    bad_op   = 1'b0;
    misalign = 1'b0;
    wstrb_n  = 4'b0000;
    wdata_n  = 32'h0;
    if (store) begin
      bad_op = (funct3 > 3'd2);
    end else begin
      bad_op = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((funct3[1:0] == 2'd1) && addr[0]) ||
               ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
`endif
    if (store) begin
      case (funct3[1:0])
        2'd0: begin
          wstrb_n = 4'b0001 << addr[1:0];
          wdata_n = {4{wdata[7:0]}};
        end
        2'd1: begin
          wstrb_n = addr[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{wdata[15:0]}};
        end
        default: begin
          wstrb_n = 4'b1111;
          wdata_n = wdata;
        end
      endcase
    end
  end

  // Lane select and extension of the returned word, using the size/offset
  // captured when the access started.
  always_comb begin
    byte_sel = mem.mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (f3_q)
      3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_ext = {24'h0, byte_sel};
      3'd5:    load_ext = {16'h0, half_sel};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  assign stall     = ((state == S_IDLE) && (load || store)) || (state == S_REQ);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      f3_q          <= 3'd0;
      off_q         <= 2'd0;
      cnt           <= 32'd0;
      done          <= 1'b0;
      rdata         <= 32'h0;
      err           <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'h0;
      mem.mem_wdata <= 32'h0;
      mem.mem_wstrb <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (load || store) begin
            f3_q  <= funct3;
            off_q <= addr[1:0];
            cnt   <= 32'd0;
            if (bad_op || misalign) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              rdata <= 32'h0;
            end else begin
              state         <= S_REQ;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= store;
              mem.mem_addr  <= {addr[31:2], 2'b00};
              mem.mem_wdata <= wdata_n;
              mem.mem_wstrb <= wstrb_n;
            end
          end
        end
        S_REQ: begin
          if (mem.mem_ack) begin
            state         <= S_DONE;
            done          <= 1'b1;
            err           <= 1'b0;
            rdata         <= mem.mem_we ? 32'h0 : load_ext;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_wstrb <= 4'b0000;
          end else if ((TIMEOUT_CYC != 0) && (cnt + 32'd1 == TIMEOUT_CYC)) begin
            // This was the last REQ cycle allowed; give up on the bus.
            state         <= S_DONE;
            done          <= 1'b1;
            err           <= 1'b1;
            rdata         <= 32'h0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_wstrb <= 4'b0000;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_DONE: begin
          // Core advances this cycle; any load/store still visible is stale.
          state <= S_IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          rdata <= 32'h0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
`timescale 1ns/1ps
module tb_lsu;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load, store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic [1:0]  dbg_state;

  lsu_if mem_bus();

  lsu #(.TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .store     (store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .dbg_state (dbg_state),
    .mem       (mem_bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];   // {err, rdata} expected at each done pulse
  logic [76:0] bus_q[$];   // {req_len[7:0], we, wstrb, addr, wdata} per bus access

  int          cur_delay = 0;  // REQ cycle index at which the memory acks
  logic [31:0] cur_rdata = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works from access size in bytes and byte offsets rather than funct3 cases.
  function automatic void model(
    input  logic        st,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    input  int          dly,
    output logic        on_bus,
    output logic [76:0] bus_e,
    output logic [32:0] done_e,
    output int          lat
  );
    int unsigned sz;
    logic        legal, mis, tmo;
    logic [31:0] lane, base, mask, v, strb, wexp;
    logic [7:0]  len;
    sz    = 32'd1 << (f3 & 3'd3);
    legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
    lane  = a & 32'd3;
    base  = lane & ~(sz - 1);
    mask  = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis   = (a % sz) != 0;
`endif
    on_bus = 1'b0;
    bus_e  = '0;
    if (!legal || mis) begin
      done_e = {1'b1, 32'h0};
      lat    = 1;
      return;
    end
    on_bus = 1'b1;
    tmo    = (dly >= TMO);
    len    = tmo ? 8'(TMO) : 8'(dly + 1);
    lat    = 2 + (tmo ? TMO - 1 : dly);
    strb   = st ? (((32'd1 << sz) - 1) << base) : 32'd0;
    wexp   = (sz == 1) ? wd[7:0] * 32'h0101_0101 :
             (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    bus_e  = {len, st, strb[3:0], a & 32'hFFFF_FFFC, wexp};
    if (tmo) begin
      done_e = {1'b1, 32'h0};
    end else if (st) begin
      done_e = {1'b0, 32'h0};
    end else begin
      v = (rd >> (8 * base)) & mask;
      if (f3 < 3'd4 && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
      done_e = {1'b0, v};
    end
  endfunction

  // ---------------- memory responder ----------------
  // Acks at REQ cycle index cur_delay; random ack noise while idle.
  initial begin
    int n;
    n = 0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_bus.mem_req && !rst) begin
        mem_bus.mem_ack   = (n == cur_delay);
        mem_bus.mem_rdata = (n == cur_delay) ? cur_rdata : $urandom;
        n++;
      end else begin
        n = 0;
        mem_bus.mem_ack   = ($urandom_range(0, 3) == 0);
        mem_bus.mem_rdata = $urandom;
      end
    end
  end

  // ---------------- done monitor ----------------
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_rdata", 64'(rdata), 64'(e[31:0]));
          check("done_err", 64'(err), 64'(e[32]));
        end
      end
    end
  end

  // ---------------- bus monitor ----------------
  initial begin
    logic        prev_req, have;
    int          req_len;
    logic [76:0] cur;
    logic [68:0] snap;
    prev_req = 1'b0; have = 1'b0; req_len = 0; cur = '0; snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0; have = 1'b0; req_len = 0;
      end else begin
        if (mem_bus.mem_req && !prev_req) begin
          snap = {mem_bus.mem_we, mem_bus.mem_wstrb, mem_bus.mem_addr, mem_bus.mem_wdata};
          req_len = 1;
          if (bus_q.size() == 0) begin
            check("unexpected_req", 64'(mem_bus.mem_req), 64'd0);
            have = 1'b0;
          end else begin
            cur  = bus_q.pop_front();
            have = 1'b1;
            check("bus_addr", 64'(mem_bus.mem_addr), 64'(cur[63:32]));
            check("bus_we", 64'(mem_bus.mem_we), 64'(cur[68]));
            check("bus_wstrb", 64'(mem_bus.mem_wstrb), 64'(cur[67:64]));
            if (cur[68]) check("bus_wdata", 64'(mem_bus.mem_wdata), 64'(cur[31:0]));
          end
        end else if (mem_bus.mem_req) begin
          req_len++;
          check("bus_stable",
                64'({mem_bus.mem_we, mem_bus.mem_wstrb, mem_bus.mem_addr, mem_bus.mem_wdata}),
                64'(snap));
        end else if (prev_req && have) begin
          check("req_len", 64'(req_len), 64'(cur[76:69]));
          have = 1'b0;
        end
        prev_req = mem_bus.mem_req;
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a negedge with the DUT idle. Leaves the instruction
  // asserted through the DONE cycle, then clears it at the next negedge.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int dly);
    logic        on_bus, got;
    logic [76:0] bus_e;
    logic [32:0] done_e;
    int          lat, cyc, stalls;
    model(st, f3, a, wd, rd, dly, on_bus, bus_e, done_e, lat);
    if (on_bus) bus_q.push_back(bus_e);
    exp_q.push_back(done_e);
    cur_delay = dly;
    cur_rdata = rd;
    load = ld; store = st; funct3 = f3; addr = a; wdata = wd;
    #1;
    check("stall_issue", 64'(stall), 64'd1);
    stalls = 1; cyc = 0; got = 1'b0;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1'b1;
      else if (stall) stalls++;
    end
    if (!got) begin
      check("done_timeout", 64'(got), 64'd1);
    end else begin
      check("latency", 64'(cyc), 64'(lat));
      check("stall_cycles", 64'(stalls), 64'(lat));
      check("stall_at_done", 64'(stall), 64'd0);
    end
    @(negedge clk);
    load = 1'b0; store = 1'b0;
  endtask

  task automatic reset_mid();
    logic        on_bus;
    logic [76:0] bus_e;
    logic [32:0] done_e;
    int          lat;
    model(1'b0, 3'd2, 32'h300, 32'h0, 32'h0, 100, on_bus, bus_e, done_e, lat);
    bus_q.push_back(bus_e);   // no done expected: the access is abandoned
    cur_delay = 100;
    load = 1'b1; store = 1'b0; funct3 = 3'd2; addr = 32'h300; wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_req", 64'(mem_bus.mem_req), 64'd0);
    check("rst_mid_state", 64'(dbg_state), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_state", 64'(dbg_state), 64'd0);
    check("post_rst_req", 64'(mem_bus.mem_req), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] f3;
    logic       ld, st;
    int         r;
    rst = 1'b1; load = 1'b0; store = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_req", 64'(mem_bus.mem_req), 64'd0);
    check("rst_we", 64'(mem_bus.mem_we), 64'd0);
    check("rst_addr", 64'(mem_bus.mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_bus.mem_wdata), 64'd0);
    check("rst_wstrb", 64'(mem_bus.mem_wstrb), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    run_op(1'b0, 1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, 32'h0, 0);         // SW
    run_op(1'b1, 1'b0, 3'd0, 32'h203, 32'h0, 32'h8011_2233, 2);         // LB
    run_op(1'b1, 1'b0, 3'd5, 32'h202, 32'h0, 32'hBEEF_1234, 0);         // LHU
    run_op(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000_ABCD, 32'h0, 1);         // SH
    run_op(1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 32'h1234_5678, 100);       // timeout
    run_op(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'hCAFE_F00D, 0);         // LW misaligned
    run_op(1'b1, 1'b0, 3'd6, 32'h100, 32'h0, 32'h0, 0);                 // bad load funct3
    run_op(1'b0, 1'b1, 3'd4, 32'h100, 32'h55, 32'h0, 0);                // bad store funct3
    run_op(1'b1, 1'b1, 3'd0, 32'h101, 32'h0000_00A5, 32'hFFFF_FFFF, 0); // both -> store
    reset_mid();
    @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      r  = $urandom_range(0, 8);
      ld = (r < 4) || (r == 8);
      st = (r >= 4);
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                       : (st ? 3'($urandom_range(0, 2))
                                             : 3'(($urandom_range(0, 1) << 2) | $urandom_range(0, 1)) |
                                               (($urandom_range(0, 4) == 0) ? 3'd2 : 3'd0));
      if (f3 == 3'd6 && $urandom_range(0, 1) == 1) f3 = 3'd2;
      run_op(ld, st, f3, $urandom, $urandom, $urandom, $urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("bus_q_drained", 64'(bus_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end of sequence");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
